// File: rtl/scp079_if.sv
// scp079_if: colour/timer inputs and state/action outputs of the scp079 supervisor
interface scp079_if;
   logic       green;
   logic       yellow;
   logic       red;
   logic [5:0] timer;
   logic [2:0] state;
   logic       a1;
   logic       a2;
   logic       a3;
   logic       cheat_out;
   modport master (output green, yellow, red, timer, input state, a1, a2, a3, cheat_out);
   modport slave  (input green, yellow, red, timer, output state, a1, a2, a3, cheat_out);
endinterface

// File: rtl/scp079.sv
// scp079: timer-sequenced supervisory FSM driving action strobes and an illegal-colour flag
module scp079 (
   input  logic    clock,
   input  logic    reset_n,
   scp079_if.slave bus
);
   typedef enum logic [2:0] {S0 = 3'd0, S1 = 3'd1, S2 = 3'd2, S3 = 3'd3, S4 = 3'd4, S5 = 3'd5} state_e;
   state_e     state_q, state_d, nxt;
   logic [2:0] act_q, act_d;
   logic       cheat_q, cheat_d;
   logic       legal, done, ovr, bad;
   logic [5:0] lim;
   always_comb begin
      legal = $onehot({bus.green, bus.yellow, bus.red});
      lim = state_q == S0 ? 6'd35 :
            state_q == S1 ? 6'd10 :
            state_q == S2 ? 6'd20 :
            state_q == S3 ? 6'd9  :
            state_q == S4 ? 6'd15 : 6'd11;
      done = bus.timer >= lim;
      bad = state_q[2] & state_q[1];
      ovr = bus.red & (state_q == S2 || state_q == S3 || state_q == S5);
      nxt = S0;
      case (state_q)
         S0: nxt = !done ? S0 : bus.green ? S2 : bus.yellow ? S1 : S4;
         S1: nxt = !done ? S1 : bus.green ? S2 : S4;
         S2: nxt = !done ? S2 : bus.green ? S3 : bus.yellow ? S1 : S4;
         S3: nxt = done ? S5 : S3;
         S4: nxt = done && bus.green ? S0 : S4;
         S5: nxt = done ? S0 : S5;
         default: nxt = S0;
      endcase
      // unreachable codes recover first; an illegal colour freezes everything else, override included
      state_d = bad ? S0 : !legal ? state_q : ovr ? S4 : nxt;
      act_d = {state_d == S2 || state_d == S5,
               state_d == S3 || state_d == S5,
               state_d == S4 || state_d == S5};
      cheat_d = !legal;
   end
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S0;
         act_q   <= 3'b000;
         cheat_q <= 1'b0;
      end else begin
         state_q <= state_d;
         act_q   <= act_d;
         cheat_q <= cheat_d;
      end
   end
   assign bus.state     = state_q;
   assign bus.a1        = act_q[2];
   assign bus.a2        = act_q[1];
   assign bus.a3        = act_q[0];
   assign bus.cheat_out = cheat_q;
endmodule

// File: tb/tb_scp079.sv
// tb_scp079: directed scenario tests for the scp079 supervisory FSM
module tb_scp079;
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   scp079_if bus();
   scp079 dut (.clock(clock), .reset_n(reset_n), .bus(bus));
   always #5 clock = ~clock;
   task automatic drive(input logic g, input logic y, input logic r, input int t);
      bus.green = g;
      bus.yellow = y;
      bus.red = r;
      bus.timer = 6'(t);
   endtask
   task automatic tick();
      @(posedge clock);
      #1;
   endtask
   task automatic test_reset();
      drive(0, 0, 1, 40);
      reset_n = 1'b0;
      tick();
      tick();
      checks++;
      if (bus.state !== 3'b000) begin errors++; $display("FAIL reset_state got %b want 000", bus.state); end
      checks++;
      if ({bus.a1, bus.a2, bus.a3} !== 3'b000) begin errors++; $display("FAIL reset_act got %b want 000", {bus.a1, bus.a2, bus.a3}); end
      checks++;
      if (bus.cheat_out !== 1'b0) begin errors++; $display("FAIL reset_cheat got %b want 0", bus.cheat_out); end
      reset_n = 1'b1;
      tick();
      checks++;
      if (bus.state !== 3'b100 || {bus.a1, bus.a2, bus.a3} !== 3'b001) begin
         errors++; $display("FAIL reset_release got %b/%b want 100/001", bus.state, {bus.a1, bus.a2, bus.a3});
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (bus.state !== 3'b000 || bus.a3 !== 1'b0) begin errors++; $display("FAIL async_reset got %b a3 %b want 000 0", bus.state, bus.a3); end
      drive(1, 0, 0, 0);
      tick();
      reset_n = 1'b1;
   endtask
   task automatic test_ok_loop();
      for (int t = 1; t <= 35; t++) begin
         drive(1, 0, 0, t);
         tick();
         if (t == 34) begin
            checks++;
            if (bus.state !== 3'b000) begin errors++; $display("FAIL s0_before_done got %b want 000", bus.state); end
         end
      end
      checks++;
      if (bus.state !== 3'b010 || {bus.a1, bus.a2, bus.a3} !== 3'b100) begin
         errors++; $display("FAIL ok_s2 got %b/%b want 010/100", bus.state, {bus.a1, bus.a2, bus.a3});
      end
      for (int t = 0; t <= 20; t++) begin
         drive(1, 0, 0, t);
         tick();
         if (t == 19) begin
            checks++;
            if (bus.state !== 3'b010) begin errors++; $display("FAIL s2_before_done got %b want 010", bus.state); end
         end
      end
      checks++;
      if (bus.state !== 3'b011 || {bus.a1, bus.a2, bus.a3} !== 3'b010) begin
         errors++; $display("FAIL ok_s3 got %b/%b want 011/010", bus.state, {bus.a1, bus.a2, bus.a3});
      end
      for (int t = 0; t <= 9; t++) begin
         drive(1, 0, 0, t);
         tick();
      end
      checks++;
      if (bus.state !== 3'b101 || {bus.a1, bus.a2, bus.a3} !== 3'b111) begin
         errors++; $display("FAIL ok_s5 got %b/%b want 101/111", bus.state, {bus.a1, bus.a2, bus.a3});
      end
      for (int t = 0; t <= 11; t++) begin
         drive(1, 0, 0, t);
         tick();
      end
      checks++;
      if (bus.state !== 3'b000 || {bus.a1, bus.a2, bus.a3} !== 3'b000) begin
         errors++; $display("FAIL ok_s0 got %b/%b want 000/000", bus.state, {bus.a1, bus.a2, bus.a3});
      end
   endtask
   task automatic test_caution();
      drive(0, 1, 0, 35);
      tick();
      checks++;
      if (bus.state !== 3'b001 || {bus.a1, bus.a2, bus.a3} !== 3'b000) begin
         errors++; $display("FAIL caution_s1 got %b/%b want 001/000", bus.state, {bus.a1, bus.a2, bus.a3});
      end
      drive(1, 0, 0, 9);
      tick();
      checks++;
      if (bus.state !== 3'b001) begin errors++; $display("FAIL s1_timer9 got %b want 001", bus.state); end
      drive(1, 0, 0, 10);
      tick();
      checks++;
      if (bus.state !== 3'b010) begin errors++; $display("FAIL s1_green got %b want 010", bus.state); end
      drive(0, 1, 0, 20);
      tick();
      checks++;
      if (bus.state !== 3'b001) begin errors++; $display("FAIL s2_yellow got %b want 001", bus.state); end
      drive(0, 0, 1, 10);
      tick();
      checks++;
      if (bus.state !== 3'b100 || {bus.a1, bus.a2, bus.a3} !== 3'b001) begin
         errors++; $display("FAIL s1_red got %b/%b want 100/001", bus.state, {bus.a1, bus.a2, bus.a3});
      end
   endtask
   task automatic test_lockdown();
      drive(0, 0, 1, 30);
      tick();
      checks++;
      if (bus.state !== 3'b100) begin errors++; $display("FAIL s4_red_hold got %b want 100", bus.state); end
      drive(0, 1, 0, 30);
      tick();
      checks++;
      if (bus.state !== 3'b100) begin errors++; $display("FAIL s4_yellow_hold got %b want 100", bus.state); end
      drive(1, 0, 0, 14);
      tick();
      checks++;
      if (bus.state !== 3'b100) begin errors++; $display("FAIL s4_timer14 got %b want 100", bus.state); end
      drive(1, 0, 0, 15);
      tick();
      checks++;
      if (bus.state !== 3'b000 || bus.a3 !== 1'b0) begin errors++; $display("FAIL s4_exit got %b a3 %b want 000 0", bus.state, bus.a3); end
   endtask
   task automatic test_red_override();
      drive(1, 0, 0, 35);
      tick();
      drive(1, 0, 0, 20);
      tick();
      checks++;
      if (bus.state !== 3'b011) begin errors++; $display("FAIL reach_s3 got %b want 011", bus.state); end
      drive(0, 0, 1, 3);
      tick();
      checks++;
      if (bus.state !== 3'b100 || {bus.a1, bus.a2, bus.a3} !== 3'b001) begin
         errors++; $display("FAIL s3_override got %b/%b want 100/001", bus.state, {bus.a1, bus.a2, bus.a3});
      end
      drive(1, 0, 0, 15);
      tick();
      drive(1, 0, 0, 35);
      tick();
      drive(0, 0, 1, 2);
      tick();
      checks++;
      if (bus.state !== 3'b100) begin errors++; $display("FAIL s2_override got %b want 100", bus.state); end
      drive(1, 0, 0, 15);
      tick();
      drive(1, 0, 0, 35);
      tick();
      drive(1, 0, 0, 20);
      tick();
      drive(1, 0, 0, 9);
      tick();
      checks++;
      if (bus.state !== 3'b101) begin errors++; $display("FAIL reach_s5 got %b want 101", bus.state); end
      drive(0, 0, 1, 0);
      tick();
      checks++;
      if (bus.state !== 3'b100) begin errors++; $display("FAIL s5_override got %b want 100", bus.state); end
      drive(1, 0, 0, 15);
      tick();
      drive(0, 0, 1, 5);
      tick();
      checks++;
      if (bus.state !== 3'b000) begin errors++; $display("FAIL s0_no_override got %b want 000", bus.state); end
   endtask
   task automatic test_illegal();
      drive(1, 1, 0, 35);
      tick();
      checks++;
      if (bus.state !== 3'b000 || bus.cheat_out !== 1'b1) begin
         errors++; $display("FAIL illegal_gy got %b cheat %b want 000 1", bus.state, bus.cheat_out);
      end
      drive(1, 0, 0, 35);
      tick();
      checks++;
      if (bus.state !== 3'b010 || bus.cheat_out !== 1'b0) begin
         errors++; $display("FAIL illegal_clear got %b cheat %b want 010 0", bus.state, bus.cheat_out);
      end
      drive(0, 0, 0, 20);
      tick();
      checks++;
      if (bus.state !== 3'b010 || bus.cheat_out !== 1'b1) begin
         errors++; $display("FAIL illegal_none got %b cheat %b want 010 1", bus.state, bus.cheat_out);
      end
      drive(1, 0, 1, 20);
      tick();
      checks++;
      if (bus.state !== 3'b010 || bus.cheat_out !== 1'b1) begin
         errors++; $display("FAIL illegal_gr_no_override got %b cheat %b want 010 1", bus.state, bus.cheat_out);
      end
      drive(1, 0, 0, 20);
      tick();
      checks++;
      if (bus.state !== 3'b011 || bus.cheat_out !== 1'b0) begin
         errors++; $display("FAIL illegal_resume got %b cheat %b want 011 0", bus.state, bus.cheat_out);
      end
   endtask
   initial begin
      drive(0, 0, 0, 0);
      test_reset();
      test_ok_loop();
      test_caution();
      test_lockdown();
      test_red_override();
      test_illegal();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
